// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX serializer between a received-byte echo
// queue and a fixed-string message streamer, one start pulse per byte.
module uart_tx_arbiter #(
  parameter int ECHO_DEPTH = 4,
  parameter int MSG_LEN    = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iECHO_VALID,
  input  logic [7:0]        iECHO_DATA,
  input  logic              iMSG_REQ,
  output logic [ADDR_W-1:0] oMSG_ADDR,
  input  logic [7:0]        iMSG_DATA,
  output logic [7:0]        oTX_DATA,
  output logic              oTX_START,
  input  logic              iTX_BUSY,
  output logic [1:0]        oGRANT,
  output logic              oBUSY,
  output logic              oECHO_OVF
);
  // state   | meaning
  // IDLE    | no grant; arbitrate once the serializer is free
  // E_LOAD  | echo byte presented, start pulse high
  // M_FETCH | message address settled, memory data arriving
  // M_LOAD  | message byte presented, or terminator seen
  // W_ACK   | waiting for the serializer to go busy
  // W_DONE  | waiting for the serializer frame to finish

  localparam int PTR_W = $clog2(ECHO_DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(ECHO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    E_LOAD  = 3'd1,
    M_FETCH = 3'd2,
    M_LOAD  = 3'd3,
    W_ACK   = 3'd4,
    W_DONE  = 3'd5
  } stateT;

  stateT             state, stateNxt;
  logic [7:0]        echoMem [ECHO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [PTR_W:0]    echoCnt;
  logic              echoAvail, echoFull, echoWr;
  logic [7:0]        echoHead;
  logic              msgPending, msgActive;
  logic              lastGrantMsg;
  logic              popEcho, grantMsg, startNxt;
  logic [7:0]        dataNxt;
  logic [ADDR_W-1:0] addrNxt;

  assign echoAvail = (echoCnt != '0);
  assign echoFull  = (echoCnt == FULL_CNT);
  assign echoHead  = echoMem[rdPtr];
  // A full queue still accepts a byte when the head leaves in the same cycle.
  assign echoWr    = iECHO_VALID && (!echoFull || popEcho);
  assign msgActive = (state != IDLE) && lastGrantMsg;

  assign oBUSY  = (state != IDLE);
  assign oGRANT = (state == IDLE) ? 2'b00 : (lastGrantMsg ? 2'b10 : 2'b01);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    popEcho  = 1'b0;
    grantMsg = 1'b0;
    startNxt = 1'b0;
    dataNxt  = oTX_DATA;
    addrNxt  = oMSG_ADDR;
    case (state)
      IDLE: begin
        if (!iTX_BUSY) begin
          if (msgPending && (!echoAvail || !lastGrantMsg)) begin
            grantMsg = 1'b1;
            addrNxt  = '0;
            stateNxt = M_FETCH;
          end else if (echoAvail) begin
            popEcho  = 1'b1;
            dataNxt  = echoHead;
            startNxt = 1'b1;
            stateNxt = E_LOAD;
          end
        end
      end
      E_LOAD: stateNxt = W_ACK;
      M_FETCH: begin
        stateNxt = M_LOAD;
        if (iMSG_DATA != 8'h00) begin
          dataNxt  = iMSG_DATA;
          startNxt = 1'b1;
        end
      end
      // No start pulse in M_LOAD means the terminator was read.
      M_LOAD: stateNxt = oTX_START ? W_ACK : IDLE;
      W_ACK: begin
        if (iTX_BUSY) stateNxt = W_DONE;
      end
      W_DONE: begin
        if (!iTX_BUSY) begin
          if (!lastGrantMsg || (oMSG_ADDR == LAST_ADDR)) begin
            stateNxt = IDLE;
          end else begin
            addrNxt  = oMSG_ADDR + 1'b1;
            stateNxt = M_FETCH;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oTX_DATA     <= 8'h00;
      oTX_START    <= 1'b0;
      oMSG_ADDR    <= '0;
      lastGrantMsg <= 1'b1;
      msgPending   <= 1'b0;
    end else begin
      oTX_DATA  <= dataNxt;
      oTX_START <= startNxt;
      oMSG_ADDR <= addrNxt;
      if (grantMsg)     lastGrantMsg <= 1'b1;
      else if (popEcho) lastGrantMsg <= 1'b0;
      if (grantMsg)                    msgPending <= 1'b0;
      else if (iMSG_REQ && !msgActive) msgPending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (echoWr) echoMem[wrPtr] <= iECHO_DATA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      echoCnt   <= '0;
      oECHO_OVF <= 1'b0;
    end else begin
      if (echoWr)  wrPtr <= wrPtr + 1'b1;
      if (popEcho) rdPtr <= rdPtr + 1'b1;
      case ({echoWr, popEcho})
        2'b10:   echoCnt <= echoCnt + 1'b1;
        2'b01:   echoCnt <= echoCnt - 1'b1;
        default: echoCnt <= echoCnt;
      endcase
      if (iECHO_VALID && echoFull && !popEcho) oECHO_OVF <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed echo/message traffic against a
// simple serializer model and a combinational message memory.
module tb_uart_tx_arbiter;
  localparam int FRAME = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       echoValid, msgReq, txBusy;
  logic [7:0] echoData, msgData, txData;
  logic [3:0] msgAddr;
  logic       txStart, dutBusy, ovf;
  logic [1:0] grant;

  logic [7:0] msgMem [16];
  logic [9:0] expQ [$];
  int         checks = 0;
  int         errors = 0;
  int         startCnt = 0;
  int         serCnt = 0;
  logic       forceBusy = 1'b0;

  always #5 clk = ~clk;
  assign msgData = msgMem[msgAddr];

  uart_tx_arbiter #(.ECHO_DEPTH(4), .MSG_LEN(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .iECHO_VALID(echoValid), .iECHO_DATA(echoData),
    .iMSG_REQ(msgReq), .oMSG_ADDR(msgAddr), .iMSG_DATA(msgData),
    .oTX_DATA(txData), .oTX_START(txStart), .iTX_BUSY(txBusy),
    .oGRANT(grant), .oBUSY(dutBusy), .oECHO_OVF(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitIdle(input int maxCyc, input string name);
    int n = 0;
    while (!(dutBusy === 1'b0 && txBusy === 1'b0 && expQ.size() == 0) && n < maxCyc) begin
      @(negedge clk); #3;
      n++;
    end
    checks++;
    if (!(dutBusy === 1'b0 && txBusy === 1'b0 && expQ.size() == 0)) begin
      errors++;
      $display("FAIL %s: not idle after %0d cycles (%0d bytes outstanding), expected idle", name, maxCyc, expQ.size());
    end
  endtask

  // Serializer model: busy for FRAME cycles after each start unless held busy.
  initial begin
    txBusy = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (forceBusy) txBusy = 1'b1;
      else if (serCnt != 0) begin
        serCnt--;
        if (serCnt == 0) txBusy = 1'b0;
      end else begin
        txBusy = 1'b0;
        if (txStart) begin
          txBusy = 1'b1;
          serCnt = FRAME;
        end
      end
    end
  end

  // Monitor: every start pulse must match the head of the scoreboard queue.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (txStart === 1'b1) begin
        startCnt++;
        checks++;
        if (txBusy !== 1'b0) begin
          errors++;
          $display("FAIL startWhileBusy: txBusy=%b, expected 0", txBusy);
        end
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL txByte: unexpected start grant=%b data=%h, expected no start", grant, txData);
        end else begin
          e = expQ.pop_front();
          if ({grant, txData} !== e) begin
            errors++;
            $display("FAIL txByte: got grant=%b data=%h, expected grant=%b data=%h",
                     grant, txData, e[9:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, expected finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int n;
    int base;
    echoValid = 1'b0; echoData = 8'h00; msgReq = 1'b0;
    for (int i = 0; i < 16; i++) msgMem[i] = 8'h00;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstTxData",  32'(txData),  32'h0);
    chk("rstTxStart", 32'(txStart), 32'h0);
    chk("rstAddr",    32'(msgAddr), 32'h0);
    chk("rstGrant",   32'(grant),   32'h0);
    chk("rstBusy",    32'(dutBusy), 32'h0);
    chk("rstOvf",     32'(ovf),     32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single echo: start two cycles after the push.
    echoValid = 1'b1; echoData = 8'h41; expQ.push_back({2'b01, 8'h41});
    @(negedge clk); echoValid = 1'b0;
    chk("echoN1Start", 32'(txStart), 32'h0);
    @(negedge clk);
    chk("echoN2Start", 32'(txStart), 32'h1);
    chk("echoN2Data",  32'(txData),  32'h41);
    chk("echoN2Grant", 32'(grant),   32'h1);
    waitIdle(50, "echoIdle");
    chk("echoIdleGrant", 32'(grant), 32'h0);

    // Message "OK\0": start three cycles after the request, two bytes only.
    msgMem[0] = 8'h4F; msgMem[1] = 8'h4B; msgMem[2] = 8'h00;
    base = startCnt;
    msgReq = 1'b1; expQ.push_back({2'b10, 8'h4F}); expQ.push_back({2'b10, 8'h4B});
    @(negedge clk); msgReq = 1'b0;
    chk("msgN1Start", 32'(txStart), 32'h0);
    @(negedge clk);
    chk("msgN2Busy",  32'(dutBusy), 32'h1);
    chk("msgN2Start", 32'(txStart), 32'h0);
    chk("msgN2Addr",  32'(msgAddr), 32'h0);
    @(negedge clk);
    chk("msgN3Start", 32'(txStart), 32'h1);
    chk("msgN3Data",  32'(txData),  32'h4F);
    chk("msgN3Grant", 32'(grant),   32'h2);
    waitIdle(100, "msgIdle");
    chk("msgFinalAddr", 32'(msgAddr), 32'h2);
    chk("msgStarts", 32'(startCnt - base), 32'd2);

    // Full-length message with no terminator.
    for (int i = 0; i < 16; i++) begin
      msgMem[i] = 8'(8'h60 + i);
      expQ.push_back({2'b10, 8'(8'h60 + i)});
    end
    base = startCnt;
    msgReq = 1'b1;
    @(negedge clk); msgReq = 1'b0;
    waitIdle(400, "fullIdle");
    chk("fullFinalAddr", 32'(msgAddr), 32'hF);
    chk("fullStarts", 32'(startCnt - base), 32'd16);

    // Arbitration: last grant was message, so a simultaneous echo wins first.
    msgMem[0] = 8'h48; msgMem[1] = 8'h49; msgMem[2] = 8'h00;
    base = startCnt;
    echoValid = 1'b1; echoData = 8'h31; msgReq = 1'b1;
    expQ.push_back({2'b01, 8'h31});
    expQ.push_back({2'b10, 8'h48});
    expQ.push_back({2'b10, 8'h49});
    @(negedge clk); echoValid = 1'b0; msgReq = 1'b0;
    @(negedge clk);
    chk("arbFirstStart", 32'(txStart), 32'h1);
    chk("arbFirstGrant", 32'(grant),   32'h1);
    chk("arbFirstData",  32'(txData),  32'h31);
    n = 0;
    while (grant !== 2'b10 && n < 100) begin @(negedge clk); n++; end
    chk("arbMsgGrant", 32'(grant), 32'h2);
    // Echo and a repeat request while the message is active.
    echoValid = 1'b1; echoData = 8'h32; msgReq = 1'b1;
    expQ.push_back({2'b01, 8'h32});
    @(negedge clk); echoValid = 1'b0; msgReq = 1'b0;
    waitIdle(200, "arbIdle");
    chk("arbStarts", 32'(startCnt - base), 32'd4);

    // Overflow: fill to exactly full, then push+pop, then push while full.
    forceBusy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      echoValid = 1'b1; echoData = 8'(8'hA1 + i); expQ.push_back({2'b01, 8'(8'hA1 + i)});
      @(negedge clk);
    end
    echoValid = 1'b0;
    chk("ovfFullNoFlag", 32'(ovf), 32'h0);
    chk("ovfHeldIdle", 32'(dutBusy), 32'h0);
    forceBusy = 1'b0;
    echoValid = 1'b1; echoData = 8'hA5; expQ.push_back({2'b01, 8'hA5});
    @(negedge clk);
    echoValid = 1'b1; echoData = 8'hA6;
    chk("ovfPopStart", 32'(txStart), 32'h1);
    chk("ovfPushPop", 32'(ovf), 32'h0);
    @(negedge clk); echoValid = 1'b0;
    chk("ovfSet", 32'(ovf), 32'h1);
    waitIdle(200, "ovfIdle");
    chk("ovfSticky", 32'(ovf), 32'h1);

    // Reset during W_DONE with the serializer still busy.
    echoValid = 1'b1; echoData = 8'h55; expQ.push_back({2'b01, 8'h55});
    @(negedge clk); echoValid = 1'b0;
    n = 0;
    while (txBusy !== 1'b1 && n < 20) begin @(negedge clk); #3; n++; end
    forceBusy = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rmfInFrame", 32'(dutBusy), 32'h1);
    reset = 1'b0;
    #1;
    chk("rmfTxData",  32'(txData),  32'h0);
    chk("rmfTxStart", 32'(txStart), 32'h0);
    chk("rmfAddr",    32'(msgAddr), 32'h0);
    chk("rmfGrant",   32'(grant),   32'h0);
    chk("rmfBusy",    32'(dutBusy), 32'h0);
    chk("rmfOvf",     32'(ovf),     32'h0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    echoValid = 1'b1; echoData = 8'h66; expQ.push_back({2'b01, 8'h66});
    @(negedge clk); echoValid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rmfHoldStart", 32'(txStart), 32'h0);
    end
    forceBusy = 1'b0;
    waitIdle(100, "rmfIdle");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
